// File: rtl/sr_cmd_pkg.sv
// Shared types for the SR command sequencer.
// Channel states, request encoding and request resolution.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_SET,
    REQ_CLR
  } req_t;

  // set+clr together collapses to clear or to nothing
  function automatic req_t resolve_req(
    input logic set,
    input logic clr,
    input logic clr_wins
  );
    req_t r;
    r = REQ_NONE;
    if (set && clr) begin
      r = clr_wins ? REQ_CLR : REQ_NONE;
    end else if (set) begin
      r = REQ_SET;
    end else if (clr) begin
      r = REQ_CLR;
    end
    return r;
  endfunction

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Request/command bundle between a driver and the sequencer.
// Requests flow master->slave, S/R commands and status flow back.
interface sr_cmd_sequencer_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] set_req;
  logic [WIDTH-1:0] clr_req;
  logic             conflict_clr;
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] q_model;
  logic [WIDTH-1:0] busy;
  logic [WIDTH-1:0] conflict;

  modport master (
    output set_req,
    output clr_req,
    output conflict_clr,
    input  s_out,
    input  r_out,
    input  q_model,
    input  busy,
    input  conflict
  );

  modport slave (
    input  set_req,
    input  clr_req,
    input  conflict_clr,
    output s_out,
    output r_out,
    output q_model,
    output busy,
    output conflict
  );

endinterface

// File: rtl/sr_cmd_channel.sv
// One channel: IDLE/PULSE/GAP sequencer with a 1-deep pending slot,
// predicted downstream Q and a sticky conflict flag.
module sr_cmd_channel
  import sr_cmd_pkg::*;
#(
  parameter int PULSE_CYCLES   = 2,
  parameter int GAP_CYCLES     = 1,
  parameter bit CLR_WINS       = 1'b1,
  parameter bit SKIP_REDUNDANT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic set_req,
  input  logic clr_req,
  input  logic conflict_clr,
  output logic s_out,
  output logic r_out,
  output logic q_model,
  output logic busy,
  output logic conflict
);

  localparam int MAXC =
    (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          pend_q, pend_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          q_q, q_d;
  logic          conf_q, conf_d;

  req_t new_req;
  req_t eff;
  logic skip;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    s_d     = s_q;
    r_d     = r_q;
    q_d     = q_q;
    conf_d  = conf_q;
    eff     = REQ_NONE;
    skip    = 1'b0;
    new_req = resolve_req(set_req, clr_req, CLR_WINS);

    if (set_req && clr_req) begin
      conf_d = 1'b1;
    end else if (conflict_clr) begin
      conf_d = 1'b0;
    end

    // downstream flop captures on every edge its S or R is high
    if (s_q) begin
      q_d = 1'b1;
    end else if (r_q) begin
      q_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        eff    = (set_req || clr_req) ? new_req : pend_q;
        pend_d = REQ_NONE;
        skip   = SKIP_REDUNDANT &&
                 (((eff == REQ_SET) && q_q) ||
                  ((eff == REQ_CLR) && !q_q));
        if ((eff != REQ_NONE) && !skip) begin
          state_d = PULSE;
          cnt_d   = CW'(PULSE_CYCLES - 1);
          s_d     = (eff == REQ_SET);
          r_d     = (eff == REQ_CLR);
        end
      end
      PULSE: begin
        if (new_req != REQ_NONE) pend_d = new_req;
        if (cnt_q == '0) begin
          s_d = 1'b0;
          r_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (new_req != REQ_NONE) pend_d = new_req;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= REQ_NONE;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      q_q     <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      s_q     <= s_d;
      r_q     <= r_d;
      q_q     <= q_d;
      conf_q  <= conf_d;
    end
  end

  assign s_out    = s_q;
  assign r_out    = r_q;
  assign q_model  = q_q;
  assign busy     = (state_q != IDLE);
  assign conflict = conf_q;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Bank of independent SR command channels.
// No arbitration between channels; conflict_clr fans out to all.
module sr_cmd_sequencer #(
  parameter int WIDTH          = 4,
  parameter int PULSE_CYCLES   = 2,
  parameter int GAP_CYCLES     = 1,
  parameter bit CLR_WINS       = 1'b1,
  parameter bit SKIP_REDUNDANT = 1'b1
) (
  input logic              clk,
  input logic              reset,
  sr_cmd_sequencer_if.slave bus
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sr_cmd_channel #(
      .PULSE_CYCLES  (PULSE_CYCLES),
      .GAP_CYCLES    (GAP_CYCLES),
      .CLR_WINS      (CLR_WINS),
      .SKIP_REDUNDANT(SKIP_REDUNDANT)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .set_req     (bus.set_req[i]),
      .clr_req     (bus.clr_req[i]),
      .conflict_clr(bus.conflict_clr),
      .s_out       (bus.s_out[i]),
      .r_out       (bus.r_out[i]),
      .q_model     (bus.q_model[i]),
      .busy        (bus.busy[i]),
      .conflict    (bus.conflict[i])
    );
  end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer: directed scenarios on three parameter
// variants plus randomized stress against a behavioural model.
module tb_sr_cmd_sequencer;

  localparam int W = 4;
  localparam int P = 2;
  localparam int G = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] set_req = '0;
  logic [W-1:0] clr_req = '0;
  logic         conflict_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_cmd_sequencer_if #(.WIDTH(W)) bus ();
  sr_cmd_sequencer_if #(.WIDTH(W)) bus_ns ();
  sr_cmd_sequencer_if #(.WIDTH(W)) bus_cw ();

  assign bus.set_req         = set_req;
  assign bus.clr_req         = clr_req;
  assign bus.conflict_clr    = conflict_clr;
  assign bus_ns.set_req      = set_req;
  assign bus_ns.clr_req      = clr_req;
  assign bus_ns.conflict_clr = conflict_clr;
  assign bus_cw.set_req      = set_req;
  assign bus_cw.clr_req      = clr_req;
  assign bus_cw.conflict_clr = conflict_clr;

  sr_cmd_sequencer #(
    .WIDTH(W), .PULSE_CYCLES(P), .GAP_CYCLES(G),
    .CLR_WINS(1'b1), .SKIP_REDUNDANT(1'b1)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  sr_cmd_sequencer #(
    .WIDTH(W), .PULSE_CYCLES(P), .GAP_CYCLES(G),
    .CLR_WINS(1'b1), .SKIP_REDUNDANT(1'b0)
  ) dut_ns (.clk(clk), .reset(reset), .bus(bus_ns));

  sr_cmd_sequencer #(
    .WIDTH(W), .PULSE_CYCLES(P), .GAP_CYCLES(G),
    .CLR_WINS(1'b0), .SKIP_REDUNDANT(1'b1)
  ) dut_cw (.clk(clk), .reset(reset), .bus(bus_cw));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (bus.s_out !== '0) begin
      failures++;
      $display("FAIL reset_s got=%b exp=0000", bus.s_out);
    end
    checks++;
    if (bus.r_out !== '0) begin
      failures++;
      $display("FAIL reset_r got=%b exp=0000", bus.r_out);
    end
    checks++;
    if (bus.q_model !== '0) begin
      failures++;
      $display("FAIL reset_q got=%b exp=0000", bus.q_model);
    end
    checks++;
    if (bus.busy !== '0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0000", bus.busy);
    end
    checks++;
    if (bus.conflict !== '0) begin
      failures++;
      $display("FAIL reset_conflict got=%b exp=0000", bus.conflict);
    end
  endtask

  // channel 0 from q=0: S high 2 cycles, q rises on 2nd, 1 gap cycle
  task automatic test_single_set();
    logic exp_s[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_q[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_b[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    set_req[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      set_req = '0;
      checks++;
      if (bus.s_out[0] !== exp_s[j]) begin
        failures++;
        $display("FAIL single_s c%0d got=%b exp=%b", j, bus.s_out[0], exp_s[j]);
      end
      checks++;
      if (bus.q_model[0] !== exp_q[j]) begin
        failures++;
        $display("FAIL single_q c%0d got=%b exp=%b", j, bus.q_model[0], exp_q[j]);
      end
      checks++;
      if (bus.busy[0] !== exp_b[j]) begin
        failures++;
        $display("FAIL single_busy c%0d got=%b exp=%b", j, bus.busy[0], exp_b[j]);
      end
      checks++;
      if (bus.r_out !== '0) begin
        failures++;
        $display("FAIL single_r c%0d got=%b exp=0000", j, bus.r_out);
      end
    end
  endtask

  task automatic test_redundant();
    logic exp_s[3] = '{1'b1, 1'b1, 1'b0};
    set_req[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      set_req = '0;
      checks++;
      if (bus.s_out[0] !== 1'b0 || bus.busy[0] !== 1'b0) begin
        failures++;
        $display("FAIL redundant_skip c%0d got s=%b busy=%b exp 0 0",
                 j, bus.s_out[0], bus.busy[0]);
      end
      checks++;
      if (bus_ns.s_out[0] !== exp_s[j] || bus_ns.busy[0] !== 1'b1) begin
        failures++;
        $display("FAIL redundant_noskip c%0d got s=%b busy=%b exp s=%b busy=1",
                 j, bus_ns.s_out[0], bus_ns.busy[0], exp_s[j]);
      end
    end
    tick();
  endtask

  task automatic test_conflict();
    logic exp_r[3] = '{1'b1, 1'b1, 1'b0};
    logic exp_q[3] = '{1'b1, 1'b0, 1'b0};
    set_req[1] = 1'b1;
    tick();
    set_req = '0;
    repeat (3) tick();
    set_req[1] = 1'b1;
    clr_req[1] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      set_req = '0;
      clr_req = '0;
      checks++;
      if (bus.r_out[1] !== exp_r[j] || bus.s_out[1] !== 1'b0) begin
        failures++;
        $display("FAIL conflict_clrwins_r c%0d got r=%b s=%b exp r=%b s=0",
                 j, bus.r_out[1], bus.s_out[1], exp_r[j]);
      end
      checks++;
      if (bus.q_model[1] !== exp_q[j]) begin
        failures++;
        $display("FAIL conflict_clrwins_q c%0d got=%b exp=%b",
                 j, bus.q_model[1], exp_q[j]);
      end
      checks++;
      if (bus.conflict[1] !== 1'b1 || bus_cw.conflict[1] !== 1'b1) begin
        failures++;
        $display("FAIL conflict_flag c%0d got=%b/%b exp=1/1",
                 j, bus.conflict[1], bus_cw.conflict[1]);
      end
      checks++;
      if (bus_cw.r_out[1] !== 1'b0 || bus_cw.s_out[1] !== 1'b0 ||
          bus_cw.busy[1] !== 1'b0 || bus_cw.q_model[1] !== 1'b1) begin
        failures++;
        $display("FAIL conflict_drop c%0d got r=%b s=%b busy=%b q=%b exp 0 0 0 1",
                 j, bus_cw.r_out[1], bus_cw.s_out[1],
                 bus_cw.busy[1], bus_cw.q_model[1]);
      end
    end
    tick();
    conflict_clr = 1'b1;
    tick();
    conflict_clr = 1'b0;
    checks++;
    if (bus.conflict !== '0 || bus_cw.conflict !== '0) begin
      failures++;
      $display("FAIL conflict_clear got=%b/%b exp=0000/0000",
               bus.conflict, bus_cw.conflict);
    end
    conflict_clr = 1'b1;
    set_req[2] = 1'b1;
    clr_req[2] = 1'b1;
    tick();
    conflict_clr = 1'b0;
    set_req = '0;
    clr_req = '0;
    checks++;
    if (bus.conflict !== 4'b0100) begin
      failures++;
      $display("FAIL conflict_event_wins got=%b exp=0100", bus.conflict);
    end
    repeat (4) tick();
    conflict_clr = 1'b1;
    tick();
    conflict_clr = 1'b0;
  endtask

  // ch0: newest pending set is redundant; ch3: pending clear is served
  task automatic test_pending_overwrite();
    logic e0_s[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic e0_b[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic e3_s[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic e3_r[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic e3_b[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req[0] = 1'b1;
    set_req[3] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      set_req = '0;
      clr_req = '0;
      if (j == 0) begin
        clr_req[0] = 1'b1;
        clr_req[3] = 1'b1;
      end
      if (j == 1) set_req[0] = 1'b1;
      checks++;
      if (bus.s_out[0] !== e0_s[j] || bus.r_out[0] !== 1'b0 ||
          bus.busy[0] !== e0_b[j]) begin
        failures++;
        $display("FAIL pend_ch0 c%0d got s=%b r=%b busy=%b exp s=%b r=0 busy=%b",
                 j, bus.s_out[0], bus.r_out[0], bus.busy[0], e0_s[j], e0_b[j]);
      end
      checks++;
      if (bus.s_out[3] !== e3_s[j] || bus.r_out[3] !== e3_r[j] ||
          bus.busy[3] !== e3_b[j]) begin
        failures++;
        $display("FAIL pend_ch3 c%0d got s=%b r=%b busy=%b exp s=%b r=%b busy=%b",
                 j, bus.s_out[3], bus.r_out[3], bus.busy[3],
                 e3_s[j], e3_r[j], e3_b[j]);
      end
    end
    checks++;
    if (bus.q_model !== 4'b0001) begin
      failures++;
      $display("FAIL pend_q got=%b exp=0001", bus.q_model);
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req[0] = 1'b1;
    set_req[1] = 1'b1;
    clr_req[1] = 1'b1;
    tick();
    set_req = '0;
    clr_req = '0;
    tick();
    checks++;
    if (bus.s_out[0] !== 1'b1 || bus.q_model[0] !== 1'b1 ||
        bus.conflict[1] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre got s=%b q=%b conf=%b exp 1 1 1",
               bus.s_out[0], bus.q_model[0], bus.conflict[1]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.s_out, bus.r_out, bus.q_model, bus.busy, bus.conflict} !== '0) begin
      failures++;
      $display("FAIL midreset_post got s=%b r=%b q=%b busy=%b conf=%b exp all 0",
               bus.s_out, bus.r_out, bus.q_model, bus.busy, bus.conflict);
    end
    tick();
    test_single_set();
  endtask

  task automatic test_random();
    logic [W-1:0] q_ref = '0;
    logic [W-1:0] conf_ref = '0;
    logic [W-1:0] s_pre, r_pre, b_pre;
    int slen[W];
    int rlen[W];
    int idle_len[W];
    bit seen[W];
    logic exp_s, exp_r;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < W; i++) begin
      slen[i] = 0;
      rlen[i] = 0;
      idle_len[i] = 0;
      seen[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < W; i++) begin
        set_req[i] = ($urandom_range(0, 5) == 0);
        clr_req[i] = ($urandom_range(0, 5) == 0);
      end
      conflict_clr = ($urandom_range(0, 31) == 0);
      s_pre = bus.s_out;
      r_pre = bus.r_out;
      b_pre = bus.busy;
      tick();
      for (int i = 0; i < W; i++) begin
        exp_s = 1'b0;
        exp_r = 1'b0;
        if (!b_pre[i] && clr_req[i]) exp_r = q_ref[i];
        else if (!b_pre[i] && set_req[i]) exp_s = !q_ref[i];
        if (s_pre[i]) q_ref[i] = 1'b1;
        else if (r_pre[i]) q_ref[i] = 1'b0;
        if (set_req[i] && clr_req[i]) conf_ref[i] = 1'b1;
        else if (conflict_clr) conf_ref[i] = 1'b0;
        checks++;
        if (bus.q_model[i] !== q_ref[i] || bus.conflict[i] !== conf_ref[i]) begin
          failures++;
          $display("FAIL rand_model cyc%0d ch%0d got q=%b conf=%b exp q=%b conf=%b",
                   cyc, i, bus.q_model[i], bus.conflict[i], q_ref[i], conf_ref[i]);
        end
        if (!b_pre[i] && (set_req[i] || clr_req[i])) begin
          checks++;
          if (bus.s_out[i] !== exp_s || bus.r_out[i] !== exp_r ||
              bus.busy[i] !== (exp_s | exp_r)) begin
            failures++;
            $display("FAIL rand_start cyc%0d ch%0d got s=%b r=%b busy=%b exp s=%b r=%b",
                     cyc, i, bus.s_out[i], bus.r_out[i], bus.busy[i], exp_s, exp_r);
          end
        end
        checks++;
        if ((bus.s_out[i] & bus.r_out[i]) !== 1'b0 ||
            ((bus.s_out[i] | bus.r_out[i]) && !bus.busy[i])) begin
          failures++;
          $display("FAIL rand_excl cyc%0d ch%0d got s=%b r=%b busy=%b",
                   cyc, i, bus.s_out[i], bus.r_out[i], bus.busy[i]);
        end
        if ((bus.s_out[i] | bus.r_out[i]) && !(s_pre[i] | r_pre[i]) && seen[i]) begin
          checks++;
          if (idle_len[i] < G + 1) begin
            failures++;
            $display("FAIL rand_spacing cyc%0d ch%0d got=%0d exp>=%0d",
                     cyc, i, idle_len[i], G + 1);
          end
        end
        if (bus.s_out[i]) slen[i]++;
        else if (slen[i] > 0) begin
          checks++;
          if (slen[i] != P) begin
            failures++;
            $display("FAIL rand_swidth cyc%0d ch%0d got=%0d exp=%0d", cyc, i, slen[i], P);
          end
          slen[i] = 0;
        end
        if (bus.r_out[i]) rlen[i]++;
        else if (rlen[i] > 0) begin
          checks++;
          if (rlen[i] != P) begin
            failures++;
            $display("FAIL rand_rwidth cyc%0d ch%0d got=%0d exp=%0d", cyc, i, rlen[i], P);
          end
          rlen[i] = 0;
        end
        if (bus.s_out[i] | bus.r_out[i]) begin
          idle_len[i] = 0;
          seen[i] = 1'b1;
        end else begin
          idle_len[i]++;
        end
      end
      checks++;
      if ((bus_ns.s_out & bus_ns.r_out) !== '0 ||
          (bus_cw.s_out & bus_cw.r_out) !== '0) begin
        failures++;
        $display("FAIL rand_excl_variants cyc%0d got %b/%b exp 0000/0000", cyc,
                 bus_ns.s_out & bus_ns.r_out, bus_cw.s_out & bus_cw.r_out);
      end
    end
    set_req = '0;
    clr_req = '0;
    conflict_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_redundant();
    test_conflict();
    test_pending_overwrite();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_cmd_sequencer.md
Name: sr_cmd_sequencer

Overview:
- Upstream driver stage for a bank of SR flip-flops.
- Converts per-channel set/clear request strobes into S/R command pulses of guaranteed width. Never drives S=R=1.
- Inserts a guard gap between successive commands and queues one pending request per channel.
- Tracks a model of the downstream Q and flags conflicting requests.

Parameters:
- WIDTH, 4, number of independent channels.
- PULSE_CYCLES, 2, cycles each S or R pulse stays high; must be >= 1.
- GAP_CYCLES, 1, idle cycles (S=R=0) after each pulse; 0 means no gap.
- CLR_WINS, 1, 1: simultaneous set+clr resolves to clear; 0: both are dropped.
- SKIP_REDUNDANT, 1, 1: suppress a set when q_model=1 and a clear when q_model=0.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- set_req  in  WIDTH  per-channel set request, sampled each edge.
- clr_req  in  WIDTH  per-channel clear request, sampled each edge.
- conflict_clr  in  1  clears all sticky conflict flags.
- s_out  out  WIDTH  S command to the downstream SR flop, registered.
- r_out  out  WIDTH  R command to the downstream SR flop, registered.
- q_model  out  WIDTH  predicted downstream Q.
- busy  out  WIDTH  channel not in IDLE.
- conflict  out  WIDTH  sticky flag: set_req and clr_req were high together.

Behaviour:
- Reset (edge with reset=1): all channels go to IDLE. s_out, r_out, q_model, busy, conflict and pending are all cleared to 0. A pulse in progress is aborted, so S/R are low in the following cycle.
- Per-channel FSM states: IDLE, PULSE, GAP. The counter is $clog2-sized and reloaded on each state entry.
- Effective request eff in IDLE:
  - If set_req or clr_req is high this cycle, eff is that new request; any stored pending request is discarded.
  - Otherwise eff is the pending request, if one exists.
- Resolving both requests high in one cycle (any state):
  - The conflict bit is set.
  - If CLR_WINS=1, the request becomes clear; if CLR_WINS=0, the request is nothing.
- IDLE -> PULSE on eff set/clr, unless SKIP_REDUNDANT suppresses it; a suppressed request is consumed with no pulse.
  - On the transition edge, s_out (for set) or r_out (for clear) goes to 1.
  - Latency: request sampled at edge k gives S/R high during cycles k+1 .. k+PULSE_CYCLES.
- PULSE:
  - Holds for PULSE_CYCLES cycles.
  - q_model takes the new value (1 for set, 0 for clear) at the first edge where s_out/r_out is 1. This is the same edge on which the downstream flop captures.
  - When the pulse ends: go to GAP if GAP_CYCLES>0, otherwise go to IDLE. S/R drop on that edge.
- GAP: S=R=0 for GAP_CYCLES cycles, then IDLE.
- Pending (PULSE or GAP only):
  - A resolved request is stored in a 1-deep pending slot; the newest request overwrites the older one.
  - Pending is served from IDLE on the cycle after the return, so the spacing between pulses is at least GAP_CYCLES+1 idle cycles.
- SKIP_REDUNDANT evaluates eff against q_model at the moment of service, not at capture.
- Invariants:
  - s_out & r_out == 0 in every cycle.
  - The pulse width is exactly PULSE_CYCLES.
  - busy = (state != IDLE).
- conflict_clr clears all conflict bits. A conflict event in the same cycle wins, so that bit stays 1.
- Channels are fully independent. No cross-channel arbitration.

Decomposition:
- Shared package sr_cmd_pkg:
  - state enum {IDLE, PULSE, GAP};
  - request enum {REQ_NONE, REQ_SET, REQ_CLR};
  - function resolve_req(set, clr, clr_wins).
- Sub-module sr_cmd_channel: the single-channel FSM, counter, pending slot, q_model and conflict logic. The top generates WIDTH instances and fans out conflict_clr.

Test Plan:
- Defaults, channel 0: set_req pulse at cycle 2 -> s_out[0]=1 in cycles 3-4; q_model[0]=1 from cycle 4; busy[0] high cycles 3-5; r_out=0 throughout.
- Redundant request: with q_model[0]=1, set_req again -> no pulse, busy stays 0. Repeat with SKIP_REDUNDANT=0 -> full 2-cycle S pulse.
- Conflict: set_req=clr_req=1 on channel 1 with q_model=1:
  - CLR_WINS=1 -> r_out[1] high 2 cycles, q_model[1]=0, conflict[1]=1.
  - CLR_WINS=0 -> no pulse, conflict[1]=1.
  - conflict_clr -> conflict[1]=0 next cycle.
- Pending overwrite: set_req at cycle 2, clr_req at cycle 3, set_req at cycle 4 -> S pulse cycles 3-4, gap cycle 5, IDLE cycle 6. The stored set is skipped as redundant, so no R pulse ever occurs.
- Mid-pulse reset: reset asserted in cycle 4 during an S pulse -> s_out=0, q_model=0, busy=0, conflict=0 from cycle 5. A new set_req at cycle 6 behaves as in the first scenario.
- Random stress, all 4 channels, 10k cycles -> (s_out & r_out)==0 every cycle; each pulse is exactly PULSE_CYCLES long; q_model matches a behavioural SR-flop model fed by s_out/r_out.
